// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall/bubble and registered EX forwarding selects; HAZARD_PERF_CNT_EN adds perf counters.
module hazard_forward_ctrl #(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
  input  logic                        id_uses_rs1,
  input  logic                        id_uses_rs2,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd,
  input  logic                        id_regwrite,
  input  logic                        id_is_load,
  input  logic                        mem_stall,
  input  logic                        flush,
  output logic [1:0]                  ex_fwd_sel1,
  output logic [1:0]                  ex_fwd_sel2,
  output logic                        stall_if_id,
  output logic                        bubble_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_load_use_cnt,
  output logic [31:0]                 perf_fwd_cnt
`endif
);
  localparam int W = $clog2(NUM_REGS);
  logic         ex_v, ex_rw, ex_ld, mem_v, mem_rw;
  logic [W-1:0] ex_rd, mem_rd;
  logic         adv, load_use, bub, ex_hit, mem_hit;
  logic [1:0]   nsel1, nsel2;
  // Slots that never forward (x0 or no write) are masked up front.
  always_comb begin
    adv         = !mem_stall;
    ex_hit      = ex_v & ex_rw & (|ex_rd);
    mem_hit     = mem_v & mem_rw & (|mem_rd);
    load_use    = id_valid & ex_hit & ex_ld &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    bub         = flush | load_use | !id_valid;
    nsel1       = bub ? 2'd0 :
                  (ex_hit & id_uses_rs1 & (ex_rd == id_rs1)) ? 2'd2 :
                  (mem_hit & id_uses_rs1 & (mem_rd == id_rs1)) ? 2'd1 : 2'd0;
    nsel2       = bub ? 2'd0 :
                  (ex_hit & id_uses_rs2 & (ex_rd == id_rs2)) ? 2'd2 :
                  (mem_hit & id_uses_rs2 & (mem_rd == id_rs2)) ? 2'd1 : 2'd0;
    stall_if_id = mem_stall | (load_use & !flush);
    bubble_ex   = adv & (load_use | flush);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v        <= 1'b0;
      ex_rw       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_rd       <= '0;
      mem_v       <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      ex_fwd_sel1 <= 2'd0;
      ex_fwd_sel2 <= 2'd0;
    end else if (adv) begin
      mem_v       <= ex_v;
      mem_rw      <= ex_rw;
      mem_rd      <= ex_rd;
      ex_v        <= !bub;
      ex_rw       <= id_regwrite & !bub;
      ex_ld       <= id_is_load & !bub;
      ex_rd       <= id_rd;
      ex_fwd_sel1 <= nsel1;
      ex_fwd_sel2 <= nsel2;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_use_cnt <= '0;
      perf_fwd_cnt      <= '0;
    end else if (adv) begin
      perf_load_use_cnt <= perf_load_use_cnt + {31'd0, load_use & !flush};
      perf_fwd_cnt      <= perf_fwd_cnt + {31'd0, (|nsel1) | (|nsel2)};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed tests of hazard_forward_ctrl; counter checks under HAZARD_PERF_CNT_EN.
module tb_hazard_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst, id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load, mem_stall, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] ex_fwd_sel1, ex_fwd_sel2;
  logic       stall_if_id, bubble_ex;
  int         checks = 0;
  int         failures = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt, perf_fwd_cnt;
`endif
  hazard_forward_ctrl #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .mem_stall(mem_stall),
    .flush(flush), .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_load_use_cnt(perf_load_use_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                    input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = 1'b1; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
    #1;
  endtask
  task automatic nop();
    id_valid = 1'b0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_is_load = 0;
    #1;
  endtask
  task automatic flush_pipe();
    nop(); step(); step(); step();
  endtask
  task automatic test_reset();
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0; nop();
    step(); step();
    checks++; if (ex_fwd_sel1 !== 2'd0) begin failures++; $display("FAIL reset_sel1 got=%0d exp=0", ex_fwd_sel1); end
    checks++; if (ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL reset_sel2 got=%0d exp=0", ex_fwd_sel2); end
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_if_id); end
    flush = 1'b1; #1;
    checks++; if (bubble_ex !== 1'b1) begin failures++; $display("FAIL reset_flush_bubble got=%b exp=1", bubble_ex); end
    mem_stall = 1'b1; #1;
    checks++; if (bubble_ex !== 1'b0 || stall_if_id !== 1'b1) begin failures++; $display("FAIL reset_memstall got=%b%b exp=10", stall_if_id, bubble_ex); end
    flush = 1'b0; mem_stall = 1'b0; step(); rst = 1'b0; step();
  endtask
  task automatic test_back_to_back();
    id(0, 0, 0, 0, 5, 1, 0); step();
    id(5, 5, 1, 1, 6, 1, 0);
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", stall_if_id); end
    step();
    checks++; if (ex_fwd_sel1 !== 2'd2 || ex_fwd_sel2 !== 2'd2) begin failures++; $display("FAIL b2b_mem got=%0d/%0d exp=2/2", ex_fwd_sel1, ex_fwd_sel2); end
    id(0, 5, 0, 1, 7, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd1) begin failures++; $display("FAIL b2b_wb got=%0d/%0d exp=0/1", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
  endtask
  task automatic test_load_use();
    id(0, 0, 1, 0, 7, 1, 1); step();
    id(7, 0, 1, 1, 8, 1, 0);
    checks++; if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b%b exp=11", stall_if_id, bubble_ex); end
    step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL lu_bubble_sel got=%0d/%0d exp=0/0", ex_fwd_sel1, ex_fwd_sel2); end
    checks++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin failures++; $display("FAIL lu_release got=%b%b exp=00", stall_if_id, bubble_ex); end
    step();
    checks++; if (ex_fwd_sel1 !== 2'd1 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL lu_consumer got=%0d/%0d exp=1/0", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
  endtask
  task automatic test_x0();
    id(0, 0, 0, 0, 0, 1, 0); step();
    id(0, 0, 1, 1, 4, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL x0_alu got=%0d/%0d exp=0/0", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
    id(0, 0, 0, 0, 0, 1, 1); step();
    id(0, 0, 1, 1, 4, 1, 0);
    checks++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin failures++; $display("FAIL x0_load_stall got=%b%b exp=00", stall_if_id, bubble_ex); end
    step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL x0_load_sel got=%0d/%0d exp=0/0", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
  endtask
  task automatic test_priority();
    id(0, 0, 0, 0, 3, 1, 0); step();
    id(0, 0, 0, 0, 3, 1, 0); step();
    id(3, 3, 1, 0, 9, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd2 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL prio got=%0d/%0d exp=2/0", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
  endtask
  task automatic test_mem_stall();
    id(0, 0, 0, 0, 9, 1, 0); step();
    id(9, 0, 1, 0, 10, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd2) begin failures++; $display("FAIL ms_pre got=%0d exp=2", ex_fwd_sel1); end
    id(0, 9, 0, 1, 11, 1, 0); mem_stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bubble_ex !== 1'b0 || stall_if_id !== 1'b1) begin failures++; $display("FAIL ms_ctrl cyc=%0d got=%b%b exp=10", i, stall_if_id, bubble_ex); end
      step();
      checks++; if (ex_fwd_sel1 !== 2'd2 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL ms_hold cyc=%0d got=%0d/%0d exp=2/0", i, ex_fwd_sel1, ex_fwd_sel2); end
    end
    mem_stall = 1'b0; #1; step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd1) begin failures++; $display("FAIL ms_resume got=%0d/%0d exp=0/1", ex_fwd_sel1, ex_fwd_sel2); end
    flush_pipe();
  endtask
  task automatic test_flush_reset();
    id(0, 0, 0, 0, 11, 1, 1); step();
    id(11, 0, 1, 0, 12, 1, 0); flush = 1'b1; #1;
    checks++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b1) begin failures++; $display("FAIL fl_lu got=%b%b exp=01", stall_if_id, bubble_ex); end
    step(); flush = 1'b0;
    checks++; if (ex_fwd_sel1 !== 2'd0) begin failures++; $display("FAIL fl_sel got=%0d exp=0", ex_fwd_sel1); end
    flush_pipe();
    id(0, 0, 0, 0, 12, 1, 0); step();
    id(12, 0, 1, 0, 13, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd2) begin failures++; $display("FAIL rst_pre got=%0d exp=2", ex_fwd_sel1); end
    nop(); rst = 1'b1; mem_stall = 1'b1; step();
    checks++; if (ex_fwd_sel1 !== 2'd0 || ex_fwd_sel2 !== 2'd0) begin failures++; $display("FAIL rst_mid got=%0d/%0d exp=0/0", ex_fwd_sel1, ex_fwd_sel2); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (perf_load_use_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", perf_load_use_cnt, perf_fwd_cnt); end
`endif
    rst = 1'b0; mem_stall = 1'b0;
    id(12, 0, 1, 0, 14, 1, 0); step();
    checks++; if (ex_fwd_sel1 !== 2'd0) begin failures++; $display("FAIL rst_cleared got=%0d exp=0", ex_fwd_sel1); end
    flush_pipe();
  endtask
`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    id(0, 0, 0, 0, 7, 1, 1); step();
    id(7, 0, 1, 0, 8, 1, 0); step(); step();
    checks++; if (perf_load_use_cnt !== 32'd1 || perf_fwd_cnt !== 32'd1) begin failures++; $display("FAIL perf got=%0d/%0d exp=1/1", perf_load_use_cnt, perf_fwd_cnt); end
    flush_pipe();
  endtask
`endif
  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_priority();
    test_mem_stall();
    test_flush_reset();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage RV32I core: the producer of the per-operand forwarding selects the EX stage consumes, plus the load-use stall and bubble controls for IF/ID and ID/EX. It keeps its own shadow pipeline of destination-register metadata for the EX, MEM and WB slots, advanced in lockstep with the datapath pipeline registers. It registers the EX forwarding selects one cycle ahead, so the EX-stage mux selects come straight from flops.

## Interface
Parameters:
- NUM_REGS, 32: architectural register count; register index width is $clog2(NUM_REGS).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  ID source register indices.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source.
- id_rd  in  5  ID destination index.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- mem_stall  in  1  data/instruction memory not ready; whole pipeline freezes.
- flush  in  1  branch/jump taken, resolved in EX; kills the ID instruction.
- ex_fwd_sel1, ex_fwd_sel2  out  2  forwarding select for the EX operand: 0 = regfile/immediate path, 1 = WB value, 2 = MEM value; 3 is never driven.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX at the next edge.

## Operation
- Internal slots EX, MEM, WB, each holding {valid, rd, regwrite, is_load}. The EX slot also holds rs1/rs2/uses flags.
- Advance (`adv = !mem_stall`), on each edge with adv:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble if flush or load_use or !id_valid; otherwise the ID fields.
- No advance (`!adv`): all slots and the fwd regs hold.
- load_use (combinational) requires all of:
  - id_valid.
  - EX.valid, EX.is_load, EX.regwrite, and EX.rd != 0.
  - (id_uses_rs1 and id_rs1 == EX.rd) or (id_uses_rs2 and id_rs2 == EX.rd).
- Forward-select computation, registered on adv. For operand n, with next-EX source s, next-MEM = current EX, and next-WB = current MEM:
  - 2 if the next-MEM slot is valid, has regwrite, rd != 0, uses_n, and rd == s.
  - else 1 if the next-WB slot meets the same conditions.
  - else 0.
  - If next-EX is a bubble, both selects are 0.
- Priority: MEM over WB (youngest producer wins). x0 is never forwarded.
- A load in the next-MEM slot with a matching consumer cannot occur, because load_use prevents it. After a one-cycle stall the load is in WB and the select is 1.
- Stall and bubble outputs:
  - stall_if_id = mem_stall | (load_use & !flush).
  - bubble_ex = adv & (load_use | flush).
- Flush during a load_use: flush wins. No stall is taken, and the bubble is inserted for the killed instruction.

## Timing
- Reset (rst high at an edge): all slots invalid; ex_fwd_sel1/2 = 0. The combinational outputs follow, so stall_if_id = mem_stall and bubble_ex = flush & !mem_stall.
- ex_fwd_sel is valid for the entire cycle the instruction occupies EX: zero combinational delay from flops.
- Load-use costs exactly 1 bubble cycle. stall_if_id is high for exactly one cycle if mem_stall stays low.
- mem_stall has priority over flush and load_use. While it is high, nothing advances and bubble_ex = 0. The flush source holds flush until it is accepted; flush is sampled only on adv.
- rst asserted mid-operation clears all in-flight metadata at that edge regardless of mem_stall.
- Back-to-back dependent instructions (ALU then consumer): select 2 on the next cycle, select 1 on the following cycle if the consumer is one instruction further back.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds two outputs.
  - perf_load_use_cnt  out  32: increments on each edge where adv & load_use & !flush.
  - perf_fwd_cnt  out  32: increments on each adv edge where either registered next-select is nonzero.
  - Both reset to 0 on rst and wrap from 0xFFFFFFFF to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- ADD x5 then ADD x6,x5,x5 (no stalls) -> on cycle N+1 of EX, ex_fwd_sel1 = ex_fwd_sel2 = 2; no stall.
- LW x7 then ADD x8,x7,x0 -> stall_if_id = 1 and bubble_ex = 1 for one cycle; consumer enters EX with ex_fwd_sel1 = 1 and ex_fwd_sel2 = 0.
- Writes to x0 followed by a reader of x0 (ALU and load producers) -> selects stay 0 and there is no load-use stall.
- ADD x3 at both MEM and WB distances (two producers of x3) -> select = 2 (MEM priority).
- mem_stall held 4 cycles mid-dependency -> slots and ex_fwd_sel hold their values unchanged; bubble_ex = 0; the sequence completes identically afterwards.
- flush coincident with load_use, then rst pulse with mem_stall high -> stall_if_id = 0 and bubble_ex = 1; after rst the selects are 0, and (with HAZARD_PERF_CNT_EN) both counters are 0.
